// File: rtl/executa_rega_pkg.sv
// rtl/executa_rega_pkg.sv - shared states, request codes and counter helpers for the irrigation sequencer
package executa_rega_pkg;

  typedef enum logic [2:0] {
    OCIOSO,
    PARTIDA,
    REGANDO,
    PURGA,
    FALHA
  } estado_t;

  localparam logic [1:0] REGA_ASP = 2'b10;
  localparam logic [1:0] REGA_GOT = 2'b01;
  localparam int CNT_W = 16;

  // A phase of t cycles loads t-1; zero-length phases still take one cycle.
  function automatic logic [CNT_W-1:0] carga(input int unsigned t);
    if (t <= 1) return '0;
    if (t > (1 << CNT_W)) return '1;
    return CNT_W'(t - 1);
  endfunction

endpackage

// File: rtl/executa_rega_temporizador.sv
// rtl/executa_rega_temporizador.sv - loadable saturating down-counter used for all phase timing
module temporizador
  import executa_rega_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] valor_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = valor_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/executa_rega.sv
// rtl/executa_rega.sv - irrigation sequencer: pump priming, valve phase, purge and fault hold
module executa_rega
  import executa_rega_pkg::*;
#(
  parameter int unsigned T_PARTIDA = 4,
  parameter int unsigned T_ASP     = 20,
  parameter int unsigned T_GOT     = 40,
  parameter int unsigned T_PURGA   = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rega,
  input  logic       erro,
  input  logic       limpa_falha,
  output logic       bomba,
  output logic       valvula_asp,
  output logic       valvula_got,
  output logic       em_rega,
  output logic       fim_rega,
  output logic       falha
);

  estado_t          estado_q, estado_d;
  logic             asp_q, asp_d;
  logic             aborto_q, aborto_d;
  logic             load;
  logic [CNT_W-1:0] valor;
  logic             zero;
  logic             bomba_d, vasp_d, vgot_d, em_d, fim_d, falha_d;

  temporizador u_temporizador (
    .clk    (clk),
    .rst    (reset),
    .load_i (load),
    .valor_i(valor),
    .zero_o (zero)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      estado_q    <= OCIOSO;
      asp_q       <= 1'b0;
      aborto_q    <= 1'b0;
      bomba       <= 1'b0;
      valvula_asp <= 1'b0;
      valvula_got <= 1'b0;
      em_rega     <= 1'b0;
      fim_rega    <= 1'b0;
      falha       <= 1'b0;
    end else begin
      estado_q    <= estado_d;
      asp_q       <= asp_d;
      aborto_q    <= aborto_d;
      bomba       <= bomba_d;
      valvula_asp <= vasp_d;
      valvula_got <= vgot_d;
      em_rega     <= em_d;
      fim_rega    <= fim_d;
      falha       <= falha_d;
    end
  end

  // Every phase entry reloads the shared counter; erro takes priority over expiry.
  always_comb begin
    estado_d = estado_q;
    asp_d    = asp_q;
    aborto_d = aborto_q;
    load     = 1'b0;
    valor    = carga(T_PARTIDA);
    case (estado_q)
      OCIOSO: begin
        aborto_d = 1'b0;
        if (!erro && (rega == REGA_ASP || rega == REGA_GOT)) begin
          estado_d = PARTIDA;
          asp_d    = (rega == REGA_ASP);
          load     = 1'b1;
          valor    = carga(T_PARTIDA);
        end
      end
      PARTIDA, REGANDO: begin
        if (erro) begin
          estado_d = PURGA;
          aborto_d = 1'b1;
          load     = 1'b1;
          valor    = carga(T_PURGA);
        end else if (zero && estado_q == PARTIDA) begin
          estado_d = REGANDO;
          load     = 1'b1;
          valor    = asp_q ? carga(T_ASP) : carga(T_GOT);
        end else if (zero) begin
          estado_d = PURGA;
          load     = 1'b1;
          valor    = carga(T_PURGA);
        end
      end
      PURGA: begin
        if (zero) estado_d = aborto_q ? FALHA : OCIOSO;
      end
      FALHA: begin
        if (limpa_falha) begin
          estado_d = OCIOSO;
          aborto_d = 1'b0;
        end
      end
      default: estado_d = OCIOSO;
    endcase
  end

  // Outputs are decoded from the next state so they register alongside it.
  always_comb begin
    bomba_d = (estado_d == PARTIDA) || (estado_d == REGANDO);
    vasp_d  = (estado_d == REGANDO) && asp_d;
    vgot_d  = (estado_d == REGANDO) && !asp_d;
    em_d    = (estado_d != OCIOSO) && (estado_d != FALHA);
    fim_d   = (estado_q == PURGA) && (estado_d == OCIOSO);
    falha_d = (estado_d == FALHA) || ((estado_d == PURGA) && aborto_d);
  end

endmodule

// File: tb/tb_executa_rega.sv
// tb/tb_executa_rega.sv - self-checking bench for executa_rega
module tb_executa_rega;

  localparam int P = 4, R_ASP = 20, R_GOT = 40, G = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [1:0] rega = 2'b00;
  logic       erro = 1'b0;
  logic       limpa = 1'b0;
  logic       bomba, valvula_asp, valvula_got, em_rega, fim_rega, falha;
  logic [1:0] rega0 = 2'b00;
  logic       zero_in = 1'b0;
  logic       b0, a0, g0, e0, f0, x0;
  logic [5:0] obs;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  executa_rega dut (
    .clk(clk), .reset(reset), .rega(rega), .erro(erro), .limpa_falha(limpa),
    .bomba(bomba), .valvula_asp(valvula_asp), .valvula_got(valvula_got),
    .em_rega(em_rega), .fim_rega(fim_rega), .falha(falha)
  );

  executa_rega #(.T_PARTIDA(0), .T_ASP(0), .T_GOT(0), .T_PURGA(0)) dut0 (
    .clk(clk), .reset(reset), .rega(rega0), .erro(zero_in), .limpa_falha(zero_in),
    .bomba(b0), .valvula_asp(a0), .valvula_got(g0),
    .em_rega(e0), .fim_rega(f0), .falha(x0)
  );

  assign obs = {bomba, valvula_asp, valvula_got, em_rega, fim_rega, falha};

  // Reference: each accepted request expands into a queue of per-cycle output words.
  logic [5:0] exp_q[$];
  logic [5:0] cur = '0;
  bit         fault = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      exp_q.delete();
      cur   = '0;
      fault = 1'b0;
    end else if (exp_q.size() > 0) begin
      if (cur[5] && erro) begin
        exp_q.delete();
        repeat (G) exp_q.push_back(6'b000101);
        exp_q.push_back(6'b000001);
        fault = 1'b1;
      end
      cur = exp_q.pop_front();
    end else if (fault) begin
      if (limpa) begin
        fault = 1'b0;
        cur   = '0;
      end else begin
        cur = 6'b000001;
      end
    end else if (!erro && (rega == 2'b10 || rega == 2'b01)) begin
      repeat (P) exp_q.push_back(6'b100100);
      if (rega == 2'b10) repeat (R_ASP) exp_q.push_back(6'b110100);
      else repeat (R_GOT) exp_q.push_back(6'b101100);
      repeat (G) exp_q.push_back(6'b000100);
      exp_q.push_back(6'b000010);
      cur = exp_q.pop_front();
    end else begin
      cur = '0;
    end
  end

  logic fim_prev = 1'b0;

  always @(negedge clk) begin
    total++;
    if (obs !== cur) begin
      bad++;
      $display("FAIL model t=%0t got=%b expected=%b", $time, obs, cur);
    end
    total++;
    if ((valvula_asp && valvula_got) || ((valvula_asp || valvula_got) && !bomba) || (fim_rega && fim_prev)) begin
      bad++;
      $display("FAIL invariant t=%0t got bomba=%b asp=%b got=%b fim=%b fim_prev=%b expected safe", $time,
               bomba, valvula_asp, valvula_got, fim_rega, fim_prev);
    end
    fim_prev = fim_rega;
  end

  task automatic chk(input string nm, input int act, input int exp_v);
    total++;
    if (act != exp_v) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp_v);
    end
  endtask

  // tog: -1 drops rega to 00 after the first cycle, -2 holds it, >=0 toggles to 10 at that cycle.
  task automatic run_cnt(input int n, input int tog, output int cb, output int ca, output int cg,
                         output int ce, output int cf, output int cx);
    cb = 0; ca = 0; cg = 0; ce = 0; cf = 0; cx = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cb += int'(bomba); ca += int'(valvula_asp); cg += int'(valvula_got);
      ce += int'(em_rega); cf += int'(fim_rega); cx += int'(falha);
      if (tog != -2) rega = (i == tog) ? 2'b10 : 2'b00;
    end
  endtask

  typedef struct {
    logic [1:0] rega;
    logic       erro;
    logic       limpa;
    logic [5:0] expv;
  } vec_t;

  vec_t vt[14];
  int cb, ca, cg, ce, cf, cx;
  int n0e, n0a, n0f;

  initial begin
    vt[0]  = '{2'b11, 1'b0, 1'b0, 6'b000000};
    vt[1]  = '{2'b10, 1'b1, 1'b0, 6'b000000};
    vt[2]  = '{2'b00, 1'b0, 1'b1, 6'b000000};
    vt[3]  = '{2'b01, 1'b0, 1'b0, 6'b100100};
    vt[4]  = '{2'b10, 1'b0, 1'b0, 6'b100100};
    vt[5]  = '{2'b00, 1'b0, 1'b0, 6'b100100};
    vt[6]  = '{2'b00, 1'b0, 1'b0, 6'b100100};
    vt[7]  = '{2'b10, 1'b0, 1'b0, 6'b101100};
    vt[8]  = '{2'b00, 1'b1, 1'b0, 6'b000101};
    vt[9]  = '{2'b00, 1'b1, 1'b0, 6'b000101};
    vt[10] = '{2'b00, 1'b0, 1'b1, 6'b000101};
    vt[11] = '{2'b00, 1'b0, 1'b0, 6'b000001};
    vt[12] = '{2'b10, 1'b0, 1'b1, 6'b000000};
    vt[13] = '{2'b00, 1'b0, 1'b0, 6'b000000};

    repeat (2) @(negedge clk);
    chk("reset_outputs", int'(obs), 0);
    reset = 1'b0;

    for (int i = 0; i < 14; i++) begin
      rega = vt[i].rega; erro = vt[i].erro; limpa = vt[i].limpa;
      @(negedge clk);
      chk($sformatf("vec%0d", i), int'(obs), int'(vt[i].expv));
    end
    rega = 2'b00; erro = 1'b0; limpa = 1'b0;
    @(negedge clk);

    rega = 2'b10;
    run_cnt(40, -1, cb, ca, cg, ce, cf, cx);
    chk("asp_bomba", cb, 24); chk("asp_valve", ca, 20); chk("asp_em", ce, 27);
    chk("asp_fim", cf, 1); chk("asp_falha", cx, 0);

    rega = 2'b01;
    run_cnt(60, 20, cb, ca, cg, ce, cf, cx);
    chk("got_valve", cg, 40); chk("got_no_asp", ca, 0); chk("got_fim", cf, 1);

    rega = 2'b11;
    run_cnt(50, -2, cb, ca, cg, ce, cf, cx);
    chk("idle_11", cb + ca + cg + ce + cf + cx, 0);
    rega = 2'b10; erro = 1'b1;
    run_cnt(50, -2, cb, ca, cg, ce, cf, cx);
    chk("idle_erro", cb + ca + cg + ce + cf + cx, 0);
    erro = 1'b0; rega = 2'b00;
    @(negedge clk);

    rega = 2'b01;
    run_cnt(10, -1, cb, ca, cg, ce, cf, cx);
    #2 reset = 1'b1;
    #1 chk("reset_async", int'(obs), 0);
    #1 reset = 1'b0;
    @(negedge clk);
    rega = 2'b01;
    run_cnt(60, -1, cb, ca, cg, ce, cf, cx);
    chk("post_reset_got", cg, 40); chk("post_reset_fim", cf, 1); chk("post_reset_falha", cx, 0);

    rega0 = 2'b10;
    n0e = 0; n0a = 0; n0f = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rega0 = 2'b00;
      n0e += int'(e0); n0a += int'(a0); n0f += int'(f0);
    end
    chk("zero_param_em", n0e, 3); chk("zero_param_asp", n0a, 1); chk("zero_param_fim", n0f, 1);

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      rega  = 2'($urandom);
      erro  = ($urandom % 80) == 0;
      limpa = ($urandom % 8) == 0;
      if (($urandom % 1000) == 0) begin
        #2 reset = 1'b1;
        #2 reset = 1'b0;
      end
    end
    rega = 2'b00; erro = 1'b0; limpa = 1'b0;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/executa_rega.md
EXECUTA_REGA -- requirements
Module: executa_rega

Interface
REQ-001 Parameter T_PARTIDA, default 4, pump-priming cycles before any valve opens.
REQ-002 Parameter T_ASP, default 20, sprinkler valve-open cycles.
REQ-003 Parameter T_GOT, default 40, drip valve-open cycles.
REQ-004 Parameter T_PURGA, default 3, cycles of pump-off pressure release after valves close.
REQ-005 Port clk, input, 1, single system clock; all state changes on the rising edge.
REQ-006 Port reset, input, 1, asynchronous, active-high reset.
REQ-007 Port rega, input, 2, validated irrigation request: 10 sprinkler (asp), 01 drip (got); 00 and 11 are no-request.
REQ-008 Port erro, input, 1, validator error flag; 1 forbids starting and aborts a running cycle.
REQ-009 Port limpa_falha, input, 1, operator acknowledge; clears the FALHA state.
REQ-010 Port bomba, output, 1, pump enable.
REQ-011 Port valvula_asp, output, 1, sprinkler valve open.
REQ-012 Port valvula_got, output, 1, drip valve open.
REQ-013 Port em_rega, output, 1, high in every state except OCIOSO and FALHA.
REQ-014 Port fim_rega, output, 1, one-cycle pulse on normal completion.
REQ-015 Port falha, output, 1, high while an abort is in progress or held.

Function
REQ-016 The FSM SHALL have the states OCIOSO, PARTIDA, REGANDO, PURGA and FALHA; all outputs are registered.
REQ-017 In OCIOSO with erro=0 and rega equal to 10 or 01, the block SHALL latch the mode and enter PARTIDA on that edge.
REQ-018 In OCIOSO, rega equal to 00 or 11, or erro=1, SHALL leave the FSM in OCIOSO.
REQ-019 PARTIDA SHALL last exactly T_PARTIDA cycles with bomba=1 and both valves closed.
REQ-020 REGANDO SHALL last exactly T_ASP or T_GOT cycles, per the latched mode, with bomba=1 and only the selected valve open.
REQ-021 PURGA SHALL last exactly T_PURGA cycles with bomba=0 and both valves closed.
REQ-022 A normal exit from PURGA SHALL go to OCIOSO and assert fim_rega for exactly that first OCIOSO cycle.
REQ-023 Changes on rega after acceptance SHALL be ignored; the latched mode holds until the next OCIOSO.
REQ-024 erro=1 sampled in PARTIDA or REGANDO SHALL enter PURGA on the next edge, close the valves, and set falha=1.
REQ-025 An aborted cycle SHALL run the full PURGA, then enter FALHA without pulsing fim_rega.
REQ-026 erro during PURGA SHALL NOT shorten or restart the purge.
REQ-027 FALHA SHALL hold bomba, valves and em_rega at 0 and falha at 1 until limpa_falha=1, then go to OCIOSO with falha=0.
REQ-028 limpa_falha together with a valid rega in FALHA SHALL only clear the fault; the request is not accepted that cycle.
REQ-029 limpa_falha outside FALHA SHALL have no effect.
REQ-030 valvula_asp and valvula_got SHALL never both be 1, and no valve SHALL be 1 while bomba=0.
REQ-031 The shared 16-bit down-counter SHALL treat a parameter value of 0 as 1 and SHALL never wrap.

Reset
REQ-032 reset=1 SHALL force OCIOSO immediately, independent of clk, with every output at 0 and the counter and latched mode cleared.
REQ-033 Reset asserted mid-cycle or in FALHA SHALL abandon the operation with no fim_rega and no falha after release.
REQ-034 The first request SHALL be accepted on the first rising edge after reset deasserts.

Structure
REQ-035 A shared package SHALL hold the state enumeration, the request codes REGA_ASP=2'b10 and REGA_GOT=2'b01, and the counter width constant (16).
REQ-036 Phase timing SHALL use one sub-module, temporizador: a loadable down-counter with load, value and zero-flag ports, instantiated once.

Verification
REQ-037 rega=10 for one cycle, erro=0 -> bomba high 4 cycles, then valvula_asp high 20 cycles, then 3 purge cycles, then fim_rega pulse; em_rega high 27 cycles.
REQ-038 rega=01 -> valvula_got high exactly 40 cycles; rega toggled to 10 mid-run -> no change in behaviour.
REQ-039 rega=11, and separately rega=10 with erro=1, in OCIOSO -> all outputs stay 0 for 50 cycles.
REQ-040 erro=1 at REGANDO cycle 5 -> valve closes next edge, falha=1, 3 purge cycles, FALHA held; limpa_falha=1 -> OCIOSO, falha=0, no fim_rega.
REQ-041 reset pulsed between clock edges during REGANDO -> all outputs 0 immediately; next rega=01 runs a full normal cycle.
REQ-042 Assertions on every test: valvula_asp and valvula_got never both 1, no valve open while bomba=0, fim_rega never longer than one cycle.
